// File: rtl/fp_mac_sequencer_if.sv
// Operand/control handshake between the operand source and the MAC sequencer.
// The master side is the source and the slave side is the sequencer.
interface fp_mac_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] vec_len;
  logic             in_valid;
  logic             in_ready;
  logic             issue;
  logic             acc_clear;
  logic             acc_en;
  logic             busy;
  logic             done;

  modport master (
    output start, vec_len, in_valid,
    input  in_ready, issue, acc_clear, acc_en, busy, done
  );

  modport slave (
    input  start, vec_len, in_valid,
    output in_ready, issue, acc_clear, acc_en, busy, done
  );
endinterface

// File: rtl/fp_mac_sequencer.sv
// Meters a vec_len-pair dot-product job into the MAC pipeline; acc_en trails issue by PIPE_LAT cycles.
// in_ready is high only while loading; an in_valid bubble simply stalls the job, and there is no timeout.
module fp_mac_sequencer #(
  parameter int PIPE_LAT = 4,
  parameter int CNT_W    = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  fp_mac_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_issue_cnt;
  logic [CNT_W-1:0]    r_retire_cnt;
  logic [PIPE_LAT-1:0] r_vsr;
  logic                r_acc_clear;
  logic                r_done;

  logic w_in_ready;
  logic w_issue;
  logic w_acc_en;
  logic w_last_issue;
  logic w_last_retire;

  assign w_in_ready    = (r_state == S_LOAD);
  assign w_issue       = w_in_ready & bus.in_valid;
  assign w_acc_en      = r_vsr[PIPE_LAT-1];
  assign w_last_issue  = w_issue  && (r_issue_cnt  == r_len - CNT_W'(1));
  assign w_last_retire = w_acc_en && (r_retire_cnt == r_len - CNT_W'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_issue_cnt  <= '0;
      r_retire_cnt <= '0;
      r_vsr        <= '0;
      r_acc_clear  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_acc_clear <= 1'b0;
      r_done      <= 1'b0;
      // Bubbles shift through as zeros so acc_en mirrors the issue pattern exactly.
      r_vsr       <= (r_vsr << 1) | PIPE_LAT'(w_issue);
      if (w_issue)
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (w_acc_en)
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc_clear <= 1'b1;
            if (bus.vec_len != '0) begin
              r_len        <= bus.vec_len;
              r_issue_cnt  <= '0;
              r_retire_cnt <= '0;
              r_state      <= S_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (w_last_issue)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_last_retire) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.issue     = w_issue;
  assign bus.acc_clear = r_acc_clear;
  assign bus.acc_en    = w_acc_en;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_fp_mac_sequencer.sv
// Directed bench for fp_mac_sequencer: per-cycle output checks plus an acc_en timing scoreboard.
module tb_fp_mac_sequencer;
  localparam int PIPE_LAT = 4;
  localparam int CNT_W    = 8;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  fp_mac_sequencer_if #(.CNT_W(CNT_W)) bus ();

  fp_mac_sequencer #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int gcyc  = 0;
  int acc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // acc_en is expected exactly in the cycles queued when the matching issue was driven.
  task automatic chk_acc(input string tag);
    logic exp_now;
    exp_now = (acc_q.size() > 0) && (acc_q[0] == gcyc);
    chk($sformatf("%s acc_en", tag), {31'd0, bus.acc_en}, {31'd0, exp_now});
    if (exp_now) void'(acc_q.pop_front());
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s in_ready", tag),  {31'd0, bus.in_ready},  32'd0);
    chk($sformatf("%s issue", tag),     {31'd0, bus.issue},     32'd0);
    chk($sformatf("%s acc_clear", tag), {31'd0, bus.acc_clear}, 32'd0);
    chk($sformatf("%s acc_en", tag),    {31'd0, bus.acc_en},    32'd0);
    chk($sformatf("%s busy", tag),      {31'd0, bus.busy},      32'd0);
    chk($sformatf("%s done", tag),      {31'd0, bus.done},      32'd0);
  endtask

  // Cycle 0 carries the start (if st0); optional extra start at cycle xs with length xl.
  task automatic job(input string tag, input bit st0, input logic [7:0] len,
                     input logic [15:0] vmask, input int xs, input logic [7:0] xl,
                     input int ncyc, input logic [15:0] e_issue, input logic [15:0] e_rdy,
                     input logic [15:0] e_clear, input logic [15:0] e_done,
                     input logic [15:0] e_busy);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clock);
      #1;
      gcyc++;
      bus.start    = (c == 0 && st0) || (xs != 0 && c == xs);
      bus.vec_len  = (xs != 0 && c == xs) ? xl : len;
      bus.in_valid = vmask[c];
      if (e_issue[c]) acc_q.push_back(gcyc + PIPE_LAT);
      @(negedge clock);
      chk($sformatf("%s c%0d issue", tag, c),     {31'd0, bus.issue},     {31'd0, e_issue[c]});
      chk($sformatf("%s c%0d in_ready", tag, c),  {31'd0, bus.in_ready},  {31'd0, e_rdy[c]});
      chk($sformatf("%s c%0d acc_clear", tag, c), {31'd0, bus.acc_clear}, {31'd0, e_clear[c]});
      chk($sformatf("%s c%0d done", tag, c),      {31'd0, bus.done},      {31'd0, e_done[c]});
      chk($sformatf("%s c%0d busy", tag, c),      {31'd0, bus.busy},      {31'd0, e_busy[c]});
      chk_acc($sformatf("%s c%0d", tag, c));
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    // Reset held with active inputs: everything stays quiet.
    bus.start    = 1'b1;
    bus.vec_len  = 8'd3;
    bus.in_valid = 1'b1;
    #2;
    chk_all_zero("reset t0");
    @(posedge clock);
    #1;
    chk_all_zero("reset edge");
    @(negedge clock);
    resetn       = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    job("post_reset", 1'b0, 8'd0, 16'h0000, 0, 8'd0, 3,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // len 3, in_valid continuously high
    job("len3", 1'b1, 8'd3, 16'hFFFF, 0, 8'd0, 11,
        16'h000E, 16'h000E, 16'h0002, 16'h0100, 16'h01FE);

    // len 3 with a bubble at cycle 2
    job("bubble", 1'b1, 8'd3, 16'hFFFB, 0, 8'd0, 11,
        16'h001A, 16'h001E, 16'h0002, 16'h0200, 16'h03FE);

    // zero-length job goes straight to DONE
    job("len0", 1'b1, 8'd0, 16'hFFFF, 0, 8'd0, 4,
        16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'h0002);

    // start with len 5 while busy is ignored; ends on the done cycle
    job("ignore", 1'b1, 8'd3, 16'hFFFF, 3, 8'd5, 9,
        16'h000E, 16'h000E, 16'h0002, 16'h0100, 16'h01FE);
    // new start in the cycle right after done is accepted
    job("restart", 1'b1, 8'd3, 16'hFFFF, 0, 8'd0, 11,
        16'h000E, 16'h000E, 16'h0002, 16'h0100, 16'h01FE);

    // reset during DRAIN after the first retire, two pairs still in flight
    job("abort", 1'b1, 8'd3, 16'hFFFF, 0, 8'd0, 6,
        16'h000E, 16'h000E, 16'h0002, 16'h0000, 16'h003E);
    chk("abort in_flight", acc_q.size(), 32'd2);
    resetn = 1'b0;
    acc_q.delete();
    #1;
    chk_all_zero("abort async");
    job("abort_hold", 1'b0, 8'd0, 16'h0000, 0, 8'd0, 4,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    resetn = 1'b1;
    job("abort_quiet", 1'b0, 8'd0, 16'h0000, 0, 8'd0, 6,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    job("len2", 1'b1, 8'd2, 16'hFFFF, 0, 8'd0, 9,
        16'h0006, 16'h0006, 16'h0002, 16'h0080, 16'h00FE);
    chk("len2 drained", acc_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_mac_sequencer.md
Name: fp_mac_sequencer

Overview:
Control sequencer for the pipelined floating-point MAC datapath: sign determine, exponent, mantissa multiply, align/add and accumulate stages.
- Accepts a dot-product job of vec_len operand pairs.
- Meters operand pairs into the pipeline with a valid/ready handshake.
- Tracks in-flight pairs with a valid shift register.
- Drives accumulator clear/enable and signals job completion.
- Sits between the operand source (FIFO or host) and the MAC stage registers.

Parameters:
PIPE_LAT, 4, cycles from operand issue to arrival at the accumulator stage (>=1)
CNT_W, 8, width of job-length and issue/retire counters

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  job request, sampled only in IDLE
vec_len  in  CNT_W  number of operand pairs in job, latched on accepted start
in_valid  in  1  operand pair available from source
in_ready  out  1  sequencer accepts an operand pair this cycle
issue  out  1  pair enters MAC pipeline this cycle (in_valid & in_ready); loads stage-1 registers
acc_clear  out  1  one-cycle pulse zeroing the accumulator at job start
acc_en  out  1  accumulator captures pipeline output this cycle
busy  out  1  job in progress (state != IDLE)
done  out  1  one-cycle pulse: accumulator holds final job result

Behaviour:
- Reset (asynchronous, resetn low):
  - State IDLE.
  - Issue count, retire count, latched length and valid shift register all cleared.
  - Every output 0.
  - Reset mid-job aborts the job and discards in-flight pairs; no done is produced.
- States: IDLE, LOAD, DRAIN, DONE. Encoding is free.
- IDLE:
  - in_ready=0.
  - start=1 with vec_len!=0: latch vec_len, clear both counters, go to LOAD.
  - start=1 with vec_len==0: go directly to DONE.
  - acc_clear is a registered pulse, high in the first cycle after start is accepted (first LOAD cycle or the DONE cycle).
- LOAD:
  - in_ready=1; issue=in_valid.
  - Each issue increments the issue count.
  - An issue when issue count == len-1 moves to DRAIN on the next edge, so exactly len pairs are accepted.
  - in_valid low inserts a bubble; there is no timeout.
- DRAIN:
  - in_ready=0.
  - Stay until the retire count reaches len, then go to DONE.
  - The transition occurs on the edge after the cycle with the final acc_en.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy is 1 during DONE.
- Pipeline tracking:
  - Valid shift register is PIPE_LAT bits wide; bit0 is loaded with issue each cycle.
  - acc_en = bit[PIPE_LAT-1], so acc_en rises exactly PIPE_LAT cycles after the matching issue.
  - Each acc_en increments the retire count.
  - Bubbles propagate unchanged.
- start while busy is ignored, including during the DONE cycle.
- in_ready, issue and busy are combinational from the state and in_valid. done, acc_clear and acc_en come from registers.
- Counters saturate at neither end. The maximum job is 2^CNT_W-1 pairs; the counters never exceed len.
- acc_clear and the first acc_en can never coincide, because PIPE_LAT>=1.

Test Plan:
1. Reset: hold resetn=0 with start=1, in_valid=1. Required: all outputs 0. Release resetn: still IDLE, with start low and no activity.
2. PIPE_LAT=4, start=1 at cycle 0 with vec_len=3, in_valid held high. Required:
   - acc_clear and in_ready at cycle 1.
   - issue at cycles 1–3; in_ready low from cycle 4.
   - acc_en at cycles 5–7.
   - done at cycle 8; busy low at cycle 9.
3. Same job with in_valid low at cycle 2 only. Required: issue at cycles 1, 3 and 4; acc_en at cycles 5, 7 and 8; done at cycle 9.
4. start with vec_len=0. Required: acc_clear and done both high at cycle 1, no issue or acc_en, IDLE at cycle 2.
5. Pulse start with vec_len=5 at cycle 3 of a running vec_len=3 job. Required: ignored, and the job completes with exactly 3 acc_en. A new start in the cycle after done is accepted.
6. Assert resetn low during DRAIN with 2 pairs in flight. Required: acc_en stays 0 thereafter and done never pulses. A following vec_len=2 job completes normally with exactly 2 acc_en.
